// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the divider arbiter.
package div_arb_pkg;

    localparam int DEF_SIZE    = 32;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 128;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FLUSH  = 3'd3,
        S_RESP   = 3'd4
    } arb_state_t;

    // Watchdog counter width; must hold values up to TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select: first asserted request after ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any_valid
);

    logic [PW-1:0] idx;

    // Walk from the farthest slot back to ptr+1 so the nearest hit is written last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one divider among NREQ requesters: accept, launch, wait with
// watchdog, then return the result on a per-requester response handshake.
module divider_arbiter
    import div_arb_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_dividend,
    input  logic [NREQ*SIZE-1:0] req_divisor,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [SIZE-1:0]      rsp_quotient,
    output logic [SIZE-1:0]      rsp_remainder,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic                 div_start,
    output logic                 div_reset,
    output logic [SIZE-1:0]      div_dividend,
    output logic [SIZE-1:0]      div_divisor,
    input  logic [SIZE-1:0]      div_quotient,
    input  logic [SIZE-1:0]      div_remainder,
    input  logic                 div_error,
    input  logic                 div_done,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    localparam int CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t state;
    logic [GW-1:0]   ptr, grant_q, winner;
    logic            any_valid;
    logic [SIZE-1:0] opa, opb, q_r, r_r;
    logic            err_r, to_r;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0][SIZE-1:0] dvd_vec, dvs_vec;

    assign dvd_vec = req_dividend;
    assign dvs_vec = req_divisor;
    assign cnt_nxt = cnt + 1'b1;

    rr_picker #(.NREQ(NREQ), .PW(GW)) u_pick (
        .req       (req_valid),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Arbitration FSM with operand, response and watchdog registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ptr     <= GW'(NREQ - 1);
            grant_q <= '0;
            opa     <= '0;
            opb     <= '0;
            q_r     <= '0;
            r_r     <= '0;
            err_r   <= 1'b0;
            to_r    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        opa     <= dvd_vec[winner];
                        opb     <= dvs_vec[winner];
                        grant_q <= winner;
                        ptr     <= winner;
                        state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_nxt;
                    // A done in the final watchdog cycle still beats the abort.
                    if (div_done) begin
                        q_r   <= div_quotient;
                        r_r   <= div_remainder;
                        err_r <= div_error;
                        to_r  <= 1'b0;
                        state <= S_RESP;
                    end else if (cnt_nxt == CNT_LAST) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    q_r   <= '0;
                    r_r   <= '0;
                    err_r <= 1'b1;
                    to_r  <= 1'b1;
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[grant_q]) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // One-hot decode of the grant winner and the response owner.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = reset && (state == S_IDLE) && any_valid && (winner == GW'(i));
            rsp_valid[i] = (state == S_RESP) && (grant_q == GW'(i));
        end
    end

    assign div_start     = (state == S_LAUNCH);
    assign div_reset     = ~reset | (state == S_FLUSH);
    assign div_dividend  = opa;
    assign div_divisor   = opb;
    assign rsp_quotient  = q_r;
    assign rsp_remainder = r_r;
    assign rsp_error     = err_r;
    assign rsp_timeout   = to_r;
    assign busy          = (state != S_IDLE);
    assign grant_id      = grant_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a latency-programmable divider stub.
module tb_divider_arbiter;

    localparam int SIZE    = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 40;
    localparam int GW      = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
    logic [NREQ-1:0][SIZE-1:0] dvd_drv = '0, dvs_drv = '0;
    logic [NREQ*SIZE-1:0] req_dividend, req_divisor;
    logic [SIZE-1:0] rsp_quotient, rsp_remainder, div_dividend, div_divisor;
    logic [SIZE-1:0] div_quotient, div_remainder;
    logic rsp_error, rsp_timeout, div_start, div_reset, div_error, div_done, busy;
    logic [GW-1:0] grant_id;

    assign req_dividend = dvd_drv;
    assign req_divisor  = dvs_drv;

    always #5 clk = ~clk;

    divider_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .div_start(div_start), .div_reset(div_reset),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_error(div_error), .div_done(div_done),
        .busy(busy), .grant_id(grant_id)
    );

    // Divider stub: done pulses lat cycles after start; hang suppresses it.
    int lat = 5;
    bit hang = 1'b0;
    int st_cnt = 0;
    logic [SIZE-1:0] st_q = '0, st_r = '0;
    logic st_err = 1'b0;

    always @(posedge clk or posedge div_reset) begin
        if (div_reset) st_cnt <= 0;
        else if (div_start) begin
            st_cnt <= lat;
            if (div_divisor != 0) begin
                st_q <= div_dividend / div_divisor;
                st_r <= div_dividend % div_divisor;
                st_err <= 1'b0;
            end else begin
                st_q <= '1;
                st_r <= div_dividend;
                st_err <= 1'b1;
            end
        end else if (st_cnt > 0) st_cnt <= st_cnt - 1;
    end
    assign div_done      = !hang && (st_cnt == 1);
    assign div_quotient  = st_q;
    assign div_remainder = st_r;
    assign div_error     = st_err;

    // Cycle counter and pulse monitors.
    int cyc_now = 0, start_cnt = 0, dres_cnt = 0, last_dres_cyc = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;
    always @(negedge clk) begin
        if (div_start) start_cnt <= start_cnt + 1;
        if (reset && div_reset) begin
            dres_cnt <= dres_cnt + 1;
            last_dres_cyc <= cyc_now;
        end
    end

    typedef struct {
        logic [GW-1:0]   id;
        logic [SIZE-1:0] q;
        logic [SIZE-1:0] r;
        logic            err;
        logic            to;
        bit              chk_data;
    } exp_t;

    exp_t sbq[$];
    logic [SIZE-1:0] a_op [NREQ];
    logic [SIZE-1:0] b_op [NREQ];
    bit exp_to = 1'b0;
    int checks = 0, errors = 0;
    int rsp_order [8];
    int n_order = 0;
    int acc_cyc_of [NREQ];
    int rsp_cyc_of [NREQ];

    function automatic exp_t make_exp(input logic [GW-1:0] id);
        exp_t e;
        e.id       = id;
        e.to       = exp_to;
        e.err      = exp_to || (b_op[id] == 0);
        e.chk_data = exp_to || (b_op[id] != 0);
        e.q        = (exp_to || b_op[id] == 0) ? '0 : a_op[id] / b_op[id];
        e.r        = (exp_to || b_op[id] == 0) ? '0 : a_op[id] % b_op[id];
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [GW-1:0] id, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        a_op[id] = a;
        b_op[id] = b;
        dvd_drv[id] = a;
        dvs_drv[id] = b;
        req_valid[id] = 1'b1;
    endtask

    // Runs cycles: pushes expectations on accept, pops and compares on response.
    task automatic drain(input int n_rsp, input int budget);
        int got, spent;
        logic [NREQ-1:0] acc;
        logic [GW-1:0] aid, rid;
        exp_t e;
        got = 0; spent = 0; n_order = 0;
        while (got < n_rsp && spent < budget) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (acc != '0) begin
                aid = GW'($clog2(acc));
                sbq.push_back(make_exp(aid));
                acc_cyc_of[aid] = cyc_now;
            end
            if ((rsp_valid & rsp_ready) != '0) begin
                rid = GW'($clog2(rsp_valid));
                rsp_cyc_of[rid] = cyc_now;
                rsp_order[n_order] = int'(rid);
                n_order++;
                got++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: response from requester %0d, none outstanding", rid);
                end else begin
                    e = sbq.pop_front();
                    if (rsp_valid !== (NREQ'(1) << e.id)) begin
                        errors++;
                        $display("FAIL rsp_owner: rsp_valid %b, expected owner %0d", rsp_valid, e.id);
                    end
                    checks++;
                    if (rsp_error !== e.err) begin
                        errors++;
                        $display("FAIL rsp_error: got %b need %b (req %0d)", rsp_error, e.err, e.id);
                    end
                    checks++;
                    if (rsp_timeout !== e.to) begin
                        errors++;
                        $display("FAIL rsp_timeout: got %b need %b (req %0d)", rsp_timeout, e.to, e.id);
                    end
                    if (e.chk_data) begin
                        checks++;
                        if (rsp_quotient !== e.q) begin
                            errors++;
                            $display("FAIL rsp_quotient: got %0d need %0d (req %0d)", rsp_quotient, e.q, e.id);
                        end
                        checks++;
                        if (rsp_remainder !== e.r) begin
                            errors++;
                            $display("FAIL rsp_remainder: got %0d need %0d (req %0d)", rsp_remainder, e.r, e.id);
                        end
                    end
                end
            end
            step();
            req_valid = req_valid & ~acc;
            spent++;
        end
        checks++;
        if (got < n_rsp) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses need %0d", got, n_rsp);
        end
    endtask

    task automatic test_reset();
        req_valid = '1;
        #12;
        checks++;
        if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== '0 || div_start !== 1'b0 ||
            grant_id !== '0 || rsp_quotient !== '0 || rsp_error !== 1'b0 || div_dividend !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready %b busy %b rsp_valid %b start %b grant %0d, need all 0",
                     req_ready, busy, rsp_valid, div_start, grant_id);
        end
        checks++;
        if (div_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_div_reset: got %b need 1", div_reset);
        end
        req_valid = '0;
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (div_reset !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: div_reset %b busy %b, need 0 0", div_reset, busy);
        end
        step();
    endtask

    task automatic test_round_robin();
        lat = 2;
        set_req(0, 20, 4);
        set_req(3, 21, 5);
        drain(2, 100);
        checks++;
        if (rsp_order[0] != 0 || rsp_order[1] != 3) begin
            errors++;
            $display("FAIL rr_first: order %0d,%0d need 0,3", rsp_order[0], rsp_order[1]);
        end
        checks++;
        if (acc_cyc_of[3] != rsp_cyc_of[0] + 1) begin
            errors++;
            $display("FAIL back_to_back: accept at %0d, need %0d", acc_cyc_of[3], rsp_cyc_of[0] + 1);
        end
        set_req(0, 33, 6);
        set_req(3, 34, 7);
        drain(2, 100);
        checks++;
        if (rsp_order[0] != 0 || rsp_order[1] != 3) begin
            errors++;
            $display("FAIL rr_reissue: order %0d,%0d need 0,3", rsp_order[0], rsp_order[1]);
        end
        for (int k = 0; k < NREQ; k++) set_req(GW'(k), 40 + k, k + 1);
        drain(4, 200);
        checks++;
        if (rsp_order[0] != 0 || rsp_order[1] != 1 || rsp_order[2] != 2 || rsp_order[3] != 3) begin
            errors++;
            $display("FAIL rr_all: order %0d,%0d,%0d,%0d need 0,1,2,3",
                     rsp_order[0], rsp_order[1], rsp_order[2], rsp_order[3]);
        end
    endtask

    task automatic test_basic();
        int s0;
        lat = 5;
        s0 = start_cnt;
        set_req(2, 100, 7);
        drain(1, 100);
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL start_pulses: got %0d need 1", start_cnt - s0);
        end
        checks++;
        if (rsp_order[0] != 2 || grant_id !== 2'd2) begin
            errors++;
            $display("FAIL basic_owner: rsp %0d grant %0d need 2", rsp_order[0], grant_id);
        end
        checks++;
        if (rsp_cyc_of[2] - acc_cyc_of[2] != lat + 2) begin
            errors++;
            $display("FAIL basic_latency: got %0d need %0d", rsp_cyc_of[2] - acc_cyc_of[2], lat + 2);
        end
    endtask

    task automatic test_min_latency();
        lat = 1;
        set_req(0, 1000, 3);
        drain(1, 50);
        checks++;
        if (rsp_cyc_of[0] - acc_cyc_of[0] != 3) begin
            errors++;
            $display("FAIL min_latency: got %0d need 3", rsp_cyc_of[0] - acc_cyc_of[0]);
        end
    endtask

    task automatic test_div_zero();
        lat = 4;
        set_req(1, 55, 0);
        drain(1, 50);
        checks++;
        if (rsp_order[0] != 1) begin
            errors++;
            $display("FAIL div_zero_owner: got %0d need 1", rsp_order[0]);
        end
    endtask

    task automatic test_stall();
        bit hit, seen;
        logic [SIZE-1:0] sq, sr;
        logic se;
        rsp_ready = '0;
        lat = 3;
        hit = 0; seen = 0;
        set_req(1, 77, 5);
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (req_ready[1]) begin
                hit = 1;
                sbq.push_back(make_exp(2'd1));
            end
            step();
        end
        req_valid[1] = 1'b0;
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL stall_accept: req_ready[1] never seen, need 1");
        end
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_rsp: rsp_valid stayed %b, need 0010", rsp_valid);
        end
        sq = rsp_quotient; sr = rsp_remainder; se = rsp_error;
        step();
        set_req(2, 8, 2);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_quotient !== sq || rsp_remainder !== sr ||
                rsp_error !== se || req_ready !== '0) begin
                errors++;
                $display("FAIL stall_hold: cyc %0d rsp_valid %b q %0d req_ready %b, need 0010 %0d 0000",
                         k, rsp_valid, rsp_quotient, req_ready, sq);
            end
        end
        step();
        rsp_ready = '1;
        drain(2, 100);
        checks++;
        if (rsp_order[0] != 1 || rsp_order[1] != 2) begin
            errors++;
            $display("FAIL stall_order: %0d,%0d need 1,2", rsp_order[0], rsp_order[1]);
        end
    endtask

    task automatic test_timeout();
        int d0;
        hang = 1'b1;
        exp_to = 1'b1;
        d0 = dres_cnt;
        set_req(0, 123, 4);
        drain(1, 200);
        checks++;
        if (dres_cnt - d0 != 1) begin
            errors++;
            $display("FAIL flush_pulses: got %0d need 1", dres_cnt - d0);
        end
        checks++;
        if (last_dres_cyc - acc_cyc_of[0] != TIMEOUT + 1) begin
            errors++;
            $display("FAIL flush_time: got %0d need %0d", last_dres_cyc - acc_cyc_of[0], TIMEOUT + 1);
        end
        checks++;
        if (rsp_cyc_of[0] - acc_cyc_of[0] != TIMEOUT + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d need %0d", rsp_cyc_of[0] - acc_cyc_of[0], TIMEOUT + 2);
        end
        hang = 1'b0;
        exp_to = 1'b0;
    endtask

    task automatic test_done_at_limit();
        int d0;
        // Done in the last WAIT cycle still wins.
        lat = TIMEOUT - 1;
        d0 = dres_cnt;
        set_req(2, 999, 10);
        drain(1, 200);
        checks++;
        if (dres_cnt != d0 || rsp_cyc_of[2] - acc_cyc_of[2] != TIMEOUT + 1) begin
            errors++;
            $display("FAIL done_at_limit: flushes %0d latency %0d, need 0 %0d",
                     dres_cnt - d0, rsp_cyc_of[2] - acc_cyc_of[2], TIMEOUT + 1);
        end
        // One cycle later is too late.
        lat = TIMEOUT;
        exp_to = 1'b1;
        d0 = dres_cnt;
        set_req(3, 999, 10);
        drain(1, 200);
        checks++;
        if (dres_cnt - d0 != 1 || rsp_cyc_of[3] - acc_cyc_of[3] != TIMEOUT + 2) begin
            errors++;
            $display("FAIL done_past_limit: flushes %0d latency %0d, need 1 %0d",
                     dres_cnt - d0, rsp_cyc_of[3] - acc_cyc_of[3], TIMEOUT + 2);
        end
        exp_to = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit hit;
        lat = 20;
        hit = 0;
        set_req(2, 50, 5);
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (req_ready[2]) hit = 1;
            step();
        end
        req_valid[2] = 1'b0;
        repeat (4) step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || div_start !== 1'b0 ||
            grant_id !== '0 || div_dividend !== '0 || div_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: busy %b rsp_valid %b grant %0d dvd %0d div_reset %b, need 0 0 0 0 1",
                     busy, rsp_valid, grant_id, div_dividend, div_reset);
        end
        repeat (2) step();
        reset = 1'b1;
        step();
        lat = 3;
        set_req(1, 9, 3);
        drain(1, 60);
        checks++;
        if (rsp_order[0] != 1) begin
            errors++;
            $display("FAIL reset_mid_recover: owner %0d need 1", rsp_order[0]);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_min_latency();
        test_div_zero();
        test_stall();
        test_timeout();
        test_done_at_limit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
